// File: rtl/vreg_read_arbiter.sv
// vreg_read_arbiter
//   Shares the single read port of the upper vector-register bank mux
//   (registers 8..15) among N requesters. Round-robin arbitration, a
//   registered 4-bit mux select, and a captured I*L-bit response held under
//   a valid/ready handshake.
//
//   Optional build macro: VREG_ARB_PIPE_EN
//     When defined, a RESP cycle that is accepted (out_ready_i=1) while any
//     request is pending arbitrates in that same cycle and goes straight to
//     READ, giving one transaction every 2 cycles instead of every 3.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   req_i        [N]     per-requester read request (level)
//   req_idx_i    [N*4]   per-requester register index, requester r at [4r+:4]
//   gnt_o        [N]     one-hot single-cycle grant
//   sel_o        [4]     bank mux select, non-zero only in READ
//   mux_y_i      [I*L]   vector returned by the bank mux for sel_o
//   out_valid_o          response valid
//   out_ready_i          consumer accepts the response
//   out_id_o     [2]     requester that owns the response
//   out_data_o   [I*L]   captured vector, lane g at [g*L+:L]

module vreg_read_arbiter #(
  parameter int I = 20,
  parameter int L = 8,
  parameter int N = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_i,
  input  logic [N*4-1:0]   req_idx_i,
  output logic [N-1:0]     gnt_o,
  output logic [3:0]       sel_o,
  input  logic [I*L-1:0]   mux_y_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [1:0]       out_id_o,
  output logic [I*L-1:0]   out_data_o
);

`ifdef VREG_ARB_PIPE_EN
  localparam bit PIPE_EN = 1'b1;
`else
  localparam bit PIPE_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, READ, RESP} state_t;

  state_t                 state_q;
  logic [3:0]             sel_q;      // latched index of the granted request
  logic [1:0]             id_q;       // winner of the in-flight read
  logic [1:0]             rr_ptr_q;   // highest-priority requester next time
  logic                   out_valid_q;
  logic [1:0]             out_id_q;
  logic [I-1:0][L-1:0]    data_q;
  logic [I-1:0][L-1:0]    mux_v;

  // ---------------- round-robin pick ----------------
  logic       any_req;
  logic [1:0] win;
  logic [2:0] cand;
  logic [2:0] rr_nxt;
  logic [3:0] win_idx;

  // Scan from the highest offset down so the last hit (smallest offset from
  // rr_ptr_q) wins; offsets wrap modulo N.
  always_comb begin
    any_req = 1'b0;
    win     = '0;
    cand    = '0;
    for (int k = N-1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr_q} + 3'(k);
      if (cand >= 3'(N)) cand = cand - 3'(N);
      if (req_i[cand[1:0]]) begin
        win     = cand[1:0];
        any_req = 1'b1;
      end
    end
  end

  always_comb begin
    rr_nxt = {1'b0, win} + 3'd1;
    if (rr_nxt >= 3'(N)) rr_nxt = '0;
  end

  assign win_idx = req_idx_i[{win, 2'b00} +: 4];

  // Arbitration is allowed in IDLE, and with the pipelined build also in an
  // accepted RESP cycle.
  logic grant_ok, issue;
  assign grant_ok = (state_q == IDLE) ||
                    (PIPE_EN && (state_q == RESP) && out_ready_i);
  assign issue    = grant_ok && any_req;

  // gnt is a same-cycle pulse derived from the sampled requests; it is forced
  // low while reset is held so nothing is granted during reset.
  always_comb begin
    gnt_o = '0;
    if (issue && !rst) gnt_o[win] = 1'b1;
  end

  // ---------------- control FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      id_q        <= '0;
      rr_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_id_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (issue) begin
            sel_q    <= win_idx;
            id_q     <= win;
            rr_ptr_q <= rr_nxt[1:0];
            state_q  <= READ;
          end
        end
        READ: begin
          // Capture happens this edge; sel returns to 0 so the mux idles at 0.
          out_valid_q <= 1'b1;
          out_id_q    <= id_q;
          sel_q       <= '0;
          state_q     <= RESP;
        end
        RESP: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            if (issue) begin
              sel_q    <= win_idx;
              id_q     <= win;
              rr_ptr_q <= rr_nxt[1:0];
              state_q  <= READ;
            end else begin
              state_q  <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // ---------------- per-lane capture ----------------
  assign mux_v = mux_y_i;

  for (genvar g = 0; g < I; g++) begin : g_lane
    always_ff @(posedge clk or posedge rst) begin
      if (rst)                   data_q[g] <= '0;
      else if (state_q == READ)  data_q[g] <= mux_v[g];
    end
  end

  assign sel_o       = sel_q;
  assign out_valid_o = out_valid_q;
  assign out_id_o    = out_id_q;
  assign out_data_o  = data_q;

endmodule

// File: doc/vreg_read_arbiter.md
Name: vreg_read_arbiter

Overview:
- Shares the single read port of the upper vector-register bank mux (registers 8–15) among N requesters, e.g. the vector ALU operand fetch, the store unit and the debug port.
- Arbitrates round-robin and drives the mux 4-bit select.
- Captures the selected I×L vector into an output register and holds it under a valid/ready handshake until the consumer accepts it.

Parameters:
- I, 20, number of lanes per vector
- L, 8, bits per lane
- N, 3, number of requesters (legal range 2..4)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous and active-high; clears all state immediately
- req  input  N  per-requester read request; level, held until granted
- req_idx  input  N×4  per-requester vector register index (valid while req is high)
- gnt  output  N  one-hot grant, single-cycle pulse
- sel  output  4  select to the bank mux
- mux_y  input  I×L  vector returned combinationally by the bank mux for sel
- out_valid  output  1  response valid
- out_ready  input  1  consumer accepts the response
- out_id  output  2  index of the requester that owns the response
- out_data  output  I×L  captured vector

Behaviour:
- Reset values: state=IDLE, gnt=0, sel=4'b0000, out_valid=0, out_id=0, out_data=0, rr_ptr=0.
- Reset asserted mid-transaction: the in-flight transaction is dropped, no response is issued, and the requester must re-request.
- FSM has three states: IDLE, READ, RESP.
- IDLE:
  - If any req is high, pick the winner by round-robin: scan from rr_ptr upward, wrapping modulo N.
  - Pulse gnt[winner]=1 for this cycle.
  - Latch idx_q=req_idx[winner] and id_q=winner.
  - Set rr_ptr=(winner+1) mod N.
  - Go to READ.
  - Otherwise stay in IDLE with gnt=0.
- READ:
  - sel=idx_q, registered, so it is stable for the whole cycle.
  - At the clock edge, out_data<=mux_y, out_id<=id_q, out_valid<=1, then go to RESP.
- RESP:
  - out_valid=1; out_data and out_id are held stable.
  - When out_ready=1, out_valid drops at the next edge and the FSM returns to IDLE.
  - If out_ready=0, hold indefinitely.
- sel returns to 4'b0000 in IDLE and RESP, so the mux outputs zero when no read is in flight.
- Latency: grant in cycle T, out_valid rises at T+2. Minimum issue interval is 3 cycles per transaction without the optional feature.
- Out-of-bank index (idx_q[3]==0): the read is performed normally and out_data=0, because the mux default case yields 0. No error is raised.
- A requester must drop req in the cycle after its gnt, or it competes again; its rr priority is then lowest.
- req changing while not granted: only the value present in the IDLE (or grant) cycle is sampled.
- Only one transaction is in flight at a time. gnt is never asserted in READ, or in RESP while out_valid=1 and out_ready=0.

Optional Feature:
- Macro: VREG_ARB_PIPE_EN.
- When defined, RESP accepting with out_ready=1 while any req is high performs the IDLE arbitration in that same cycle:
  - gnt pulses and the latches update.
  - The next state is READ, skipping IDLE.
  - Sustained issue rate becomes one transaction per 2 cycles.
- When not defined, RESP always returns to IDLE first.
- Reset values and all other behaviour are identical in both builds.

Test Plan:
- Reset check:
  - Stimulus: assert rst asynchronously mid-cycle during READ with idx=4'hA.
  - Response: out_valid=0, sel=0, gnt=0 immediately; after release, no response for the dropped read.
- Single read:
  - Stimulus: req=3'b001, idx=4'hC, mux model returns lane k = k+1.
  - Response: gnt=001 at T; sel=C at T+1; out_valid=1, out_id=0, out_data lanes 1..20 at T+2.
- Round-robin fairness:
  - Stimulus: all three req held high continuously, out_ready=1.
  - Response: grant order 0,1,2,0,1,2; no requester starves.
- Backpressure:
  - Stimulus: out_ready=0 for 10 cycles after out_valid, with req high from another requester.
  - Response: out_data and out_id stable, no gnt until the cycle after out_ready=1.
- Out-of-bank index:
  - Stimulus: idx=4'h3.
  - Response: out_valid after 2 cycles with out_data=0.
- VREG_ARB_PIPE_EN:
  - Stimulus: req held high on two requesters, out_ready=1.
  - Response: grants every 2 cycles with the macro defined, every 3 cycles without it.
